// File: rtl/sweep_counter_pkg.sv
// rtl/sweep_counter_pkg.sv - shared mode encodings and width default for the sweep counter
package sweep_counter_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  // Saturate a requested value to the inclusive upper bound.
  function automatic logic [WIDTH_DEFAULT-1:0] clamp_default(
    input logic [WIDTH_DEFAULT-1:0] value,
    input logic [WIDTH_DEFAULT-1:0] bound
  );
    return (value > bound) ? bound : value;
  endfunction

endpackage

// File: rtl/sweep_counter_if.sv
// rtl/sweep_counter_if.sv - control and status bundle between a driver and the sweep counter
interface sweep_counter_if
  import sweep_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             en;
  mode_e            mode;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             wrap;

  modport master (
    output en, mode, step, limit, load, load_value,
    input  count, dir, wrap
  );

  modport slave (
    input  en, mode, step, limit, load, load_value,
    output count, dir, wrap
  );

endinterface

// File: rtl/sweep_counter_next.sv
// rtl/sweep_counter_next.sv - combinational next count, direction and wrap for the sweep counter
module sweep_counter_next
  import sweep_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             en,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  output logic [WIDTH-1:0] count_nxt,
  output logic             dir_nxt,
  output logic             wrap_nxt
);

  // One extra bit keeps count + step from aliasing back below limit.
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   limit_x;
  logic [WIDTH-1:0] diff;
  logic             above_limit;
  logic             below_step;
  logic             at_or_below_step;

  assign sum_x            = {1'b0, count} + {1'b0, step};
  assign limit_x          = {1'b0, limit};
  assign diff             = count - step;
  assign above_limit      = count > limit;
  assign below_step       = count < step;
  assign at_or_below_step = count <= step;

  always_comb begin
    count_nxt = count;
    dir_nxt   = dir;
    wrap_nxt  = 1'b0;
    if (load) begin
      count_nxt = (load_value > limit) ? limit : load_value;
      dir_nxt   = 1'b0;
    end else if (en) begin
      case (mode)
        MODE_UP: begin
          if (sum_x > limit_x) begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
          end else begin
            count_nxt = sum_x[WIDTH-1:0];
          end
        end
        MODE_DOWN: begin
          if (above_limit) begin
            count_nxt = limit;
          end else if (below_step) begin
            count_nxt = limit;
            wrap_nxt  = 1'b1;
          end else begin
            count_nxt = diff;
          end
        end
        MODE_TRI: begin
          if (!dir) begin
            if (sum_x >= limit_x) begin
              count_nxt = limit;
              dir_nxt   = 1'b1;
            end else begin
              count_nxt = sum_x[WIDTH-1:0];
            end
          end else begin
            // A lowered limit pulls the falling edge back inside the range first.
            if (above_limit) begin
              count_nxt = limit;
            end else if (at_or_below_step) begin
              count_nxt = '0;
              dir_nxt   = 1'b0;
              wrap_nxt  = 1'b1;
            end else begin
              count_nxt = diff;
            end
          end
        end
        default: begin
          count_nxt = count;
        end
      endcase
    end
  end

endmodule

// File: rtl/sweep_counter.sv
// rtl/sweep_counter.sv - up/down/triangle sweep counter with load and one-cycle wrap pulse
module sweep_counter
  import sweep_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  sweep_counter_if.slave    bus
);

  logic [WIDTH-1:0] count_q;
  logic             dir_q;
  logic             wrap_q;
  logic [WIDTH-1:0] count_nxt;
  logic             dir_nxt;
  logic             wrap_nxt;

  sweep_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .en         (bus.en),
    .mode       (bus.mode),
    .step       (bus.step),
    .limit      (bus.limit),
    .load       (bus.load),
    .load_value (bus.load_value),
    .count      (count_q),
    .dir        (dir_q),
    .count_nxt  (count_nxt),
    .dir_nxt    (dir_nxt),
    .wrap_nxt   (wrap_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      dir_q   <= dir_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_sweep_counter.sv
// tb/tb_sweep_counter.sv - directed vector bench for the sweep counter
module tb_sweep_counter;
  import sweep_counter_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic         rst;
    logic         en;
    mode_e        mode;
    logic [W-1:0] step;
    logic [W-1:0] limit;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] exp_count;
    logic         exp_dir;
    logic         exp_wrap;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  vec_t vecs[$];

  sweep_counter_if #(.WIDTH(W)) bus ();

  sweep_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void add(input logic r, input logic e, input mode_e m,
                              input int s, input int l, input logic ld, input int lv,
                              input int c, input logic d, input logic w);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m;
    v.step = W'(s); v.limit = W'(l);
    v.load = ld; v.load_value = W'(lv);
    v.exp_count = W'(c); v.exp_dir = d; v.exp_wrap = w;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input string tag);
    rst            = v.rst;
    bus.en         = v.en;
    bus.mode       = v.mode;
    bus.step       = v.step;
    bus.limit      = v.limit;
    bus.load       = v.load;
    bus.load_value = v.load_value;
    @(posedge clk);
    #1;
    check({tag, ".count"}, int'(bus.count), int'(v.exp_count));
    check({tag, ".dir"},   int'(bus.dir),   int'(v.exp_dir));
    check({tag, ".wrap"},  int'(bus.wrap),  int'(v.exp_wrap));
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    bus.en = 1'b0; bus.mode = MODE_HOLD; bus.step = '0; bus.limit = '0;
    bus.load = 1'b0; bus.load_value = '0;
    @(negedge clk);

    //  rst en mode       stp lim ld lv   cnt dir wrap
    add(1, 0, MODE_UP,    0,  0,  0, 0,   0,  0, 0);
    add(0, 1, MODE_UP,    3,  10, 0, 0,   3,  0, 0);
    add(0, 1, MODE_UP,    3,  10, 0, 0,   6,  0, 0);
    add(0, 1, MODE_UP,    3,  10, 0, 0,   9,  0, 0);
    add(0, 1, MODE_UP,    3,  10, 0, 0,   0,  0, 1);
    add(0, 1, MODE_UP,    3,  10, 0, 0,   3,  0, 0);
    add(1, 1, MODE_UP,    3,  10, 1, 99,  0,  0, 0);
    add(0, 1, MODE_DOWN,  4,  10, 0, 0,   10, 0, 1);
    add(0, 1, MODE_DOWN,  4,  10, 0, 0,   6,  0, 0);
    add(0, 1, MODE_DOWN,  4,  10, 0, 0,   2,  0, 0);
    add(0, 1, MODE_DOWN,  4,  10, 0, 0,   10, 0, 1);
    add(0, 1, MODE_DOWN,  4,  10, 0, 0,   6,  0, 0);
    add(1, 0, MODE_TRI,   4,  10, 0, 0,   0,  0, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   4,  0, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   8,  0, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   10, 1, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   6,  1, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   2,  1, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   0,  0, 1);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   4,  0, 0);
    add(0, 1, MODE_HOLD,  4,  10, 0, 0,   4,  0, 0);
    add(0, 1, MODE_HOLD,  4,  10, 0, 0,   4,  0, 0);
    // load clamps to limit, then en low holds
    add(0, 1, MODE_UP,    3,  100, 1, 200, 100, 0, 0);
    add(0, 0, MODE_UP,    3,  100, 0, 0,   100, 0, 0);
    add(0, 0, MODE_UP,    3,  100, 0, 0,   100, 0, 0);
    add(0, 0, MODE_UP,    3,  100, 0, 0,   100, 0, 0);
    // limit 0 with nonzero step wraps every enabled cycle
    add(0, 1, MODE_UP,    5,  0,  0, 0,   0,  0, 1);
    add(0, 1, MODE_UP,    5,  0,  0, 0,   0,  0, 1);
    add(0, 1, MODE_DOWN,  5,  0,  0, 0,   0,  0, 1);
    // step 0 leaves count alone
    add(0, 0, MODE_HOLD,  0,  10, 1, 5,   5,  0, 0);
    add(0, 1, MODE_UP,    0,  10, 0, 0,   5,  0, 0);
    add(0, 1, MODE_DOWN,  0,  10, 0, 0,   5,  0, 0);
    // dir survives a detour through UP
    add(0, 1, MODE_TRI,   4,  10, 1, 0,   0,  0, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   4,  0, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   8,  0, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   10, 1, 0);
    add(0, 1, MODE_UP,    4,  10, 0, 0,   0,  1, 1);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   0,  0, 1);
    // lowered limit clamps a falling triangle
    add(0, 1, MODE_TRI,   4,  10, 1, 0,   0,  0, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   4,  0, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   8,  0, 0);
    add(0, 1, MODE_TRI,   4,  10, 0, 0,   10, 1, 0);
    add(0, 1, MODE_TRI,   4,  5,  0, 0,   5,  1, 0);
    add(0, 1, MODE_TRI,   4,  5,  0, 0,   1,  1, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-sweep overrides a simultaneous load, then counting restarts from 0.
    v = '{rst: 1, en: 1, mode: MODE_TRI, step: 4, limit: 10, load: 0, load_value: 0,
          exp_count: 0, exp_dir: 0, exp_wrap: 0};
    apply(v, "mid.rst0");
    v.rst = 0;
    v.exp_count = 4;  apply(v, "mid.up4");
    v.exp_count = 8;  apply(v, "mid.up8");
    v.exp_count = 10; v.exp_dir = 1; apply(v, "mid.top");
    v.exp_count = 6;  apply(v, "mid.down6");
    v.rst = 1; v.load = 1; v.load_value = 50;
    v.exp_count = 0;  v.exp_dir = 0; apply(v, "mid.rst_load");
    v.rst = 0; v.load = 0;
    v.exp_count = 4;  apply(v, "mid.restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
